// File: rtl/seq_alu_pkg.sv
// Shared definitions for seq_alu: operation codes and FSM state encoding.
package seq_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier, one multiplier bit per step.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   load        capture a, b; clear accumulator and iteration counter
//   step        perform one shift-add iteration
//   a, b        multiplicand / multiplier (W bits)
//   last_c      current step is the final (W-th) iteration
//   product_c   accumulator value after the current step (2W bits)
module alu_mul_seq #(
  parameter int unsigned W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  output logic            last_c,
  output logic [2*W-1:0]  product_c
);

  localparam int unsigned RW = 2 * W;
  localparam int unsigned CW = $clog2(W);

  logic [RW-1:0] mcand;
  logic [RW-1:0] acc;
  logic [W-1:0]  mplier;
  logic [CW-1:0] cnt;
  logic [RW-1:0] addend_c;

  // Exposing the post-step sum lets the top register the product on the last edge.
  always_comb begin
    addend_c  = mplier[0] ? mcand : '0;
    product_c = acc + addend_c;
    last_c    = (cnt == CW'(W - 1));
  end

  // Multiplicand shifts left, multiplier shifts right: bit i meets a << i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= RW'(a);
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      acc    <= product_c;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU: eight operations on latched operands; MUL iterates W cycles.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   start       request strobe, accepted only in IDLE
//   a, b        operands (W bits); cin carry/borrow in; sel operation
//   busy        high while a multiply is iterating
//   done        one-cycle pulse when result/flag/zero are updated
//   result      2W-bit registered result; flag carry/borrow/overflow; zero
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic            cin,
  input  logic [2:0]      sel,
  output logic            busy,
  output logic            done,
  output logic [2*W-1:0]  result,
  output logic            flag,
  output logic            zero
);

  localparam int unsigned RW  = 2 * W;
  localparam int unsigned SHW = $clog2(W) + 1;

  state_t         state, state_next;
  logic [W-1:0]   a_q, b_q;
  logic           cin_q;
  logic [2:0]     sel_q;
  logic           pend_q;

  logic           accept_c;
  logic           mul_load_c, mul_step_c, mul_last_c;
  logic [RW-1:0]  mul_prod_c;
  logic           busy_next_c, done_next_c, upd_c;
  logic [RW-1:0]  res_next_c;
  logic           flag_next_c, zero_next_c;

  logic [W:0]     sum_c, diff_c;
  logic [RW-1:0]  shl_c, alu_res_c;
  logic           alu_flag_c, alu_zero_c;

  assign accept_c = start && (state == ST_IDLE);

  alu_mul_seq #(.W(W)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (mul_load_c),
    .step      (mul_step_c),
    .a         (a),
    .b         (b),
    .last_c    (mul_last_c),
    .product_c (mul_prod_c)
  );

  // Single-cycle datapath, decoded from the latched operation.
  always_comb begin
    sum_c      = {1'b0, a_q} + {1'b0, b_q} + (W+1)'(cin_q);
    diff_c     = {1'b0, a_q} - {1'b0, b_q} - (W+1)'(cin_q);
    shl_c      = RW'(a_q) << b_q[SHW-1:0];
    alu_res_c  = '0;
    alu_flag_c = 1'b0;
    case (sel_q)
      OP_ADD: begin
        alu_res_c  = RW'(sum_c);
        alu_flag_c = sum_c[W];
      end
      OP_SUB: begin
        // Bit W of the (W+1)-bit difference is set exactly when a < b + cin.
        alu_res_c  = RW'(diff_c[W-1:0]);
        alu_flag_c = diff_c[W];
      end
      OP_AND: alu_res_c = RW'(a_q & b_q);
      OP_OR:  alu_res_c = RW'(a_q | b_q);
      OP_XOR: alu_res_c = RW'(a_q ^ b_q);
      OP_SHL: begin
        if (32'(b_q[SHW-1:0]) >= 32'(RW)) alu_res_c = '0;
        else                              alu_res_c = shl_c;
        alu_flag_c = |alu_res_c[RW-1:W];
      end
      OP_CMP: alu_flag_c = (a_q < b_q);
      default: alu_res_c = '0;
    endcase
    alu_zero_c = (sel_q == OP_CMP) ? (a_q == b_q) : (alu_res_c == '0);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state and next output values.
  always_comb begin
    state_next  = state;
    mul_load_c  = 1'b0;
    mul_step_c  = 1'b0;
    busy_next_c = 1'b0;
    done_next_c = 1'b0;
    upd_c       = 1'b0;
    res_next_c  = alu_res_c;
    flag_next_c = alu_flag_c;
    zero_next_c = alu_zero_c;
    case (state)
      ST_IDLE: begin
        // A single-cycle op accepted last edge retires now, even if a new start is accepted.
        if (pend_q) begin
          upd_c       = 1'b1;
          done_next_c = 1'b1;
        end
        if (accept_c && (sel == OP_MUL)) begin
          state_next = ST_MUL;
          mul_load_c = 1'b1;
        end
      end
      ST_MUL: begin
        mul_step_c = 1'b1;
        if (mul_last_c) begin
          state_next  = ST_IDLE;
          upd_c       = 1'b1;
          done_next_c = 1'b1;
          res_next_c  = mul_prod_c;
          flag_next_c = |mul_prod_c[RW-1:W];
          zero_next_c = (mul_prod_c == '0);
        end else begin
          busy_next_c = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand latch and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      cin_q  <= 1'b0;
      sel_q  <= OP_ADD;
      pend_q <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      flag   <= 1'b0;
      zero   <= 1'b0;
    end else begin
      if (accept_c) begin
        a_q   <= a;
        b_q   <= b;
        cin_q <= cin;
        sel_q <= sel;
      end
      pend_q <= accept_c && (sel != OP_MUL);
      busy   <= busy_next_c;
      done   <= done_next_c;
      if (upd_c) begin
        result <= res_next_c;
        flag   <= flag_next_c;
        zero   <= zero_next_c;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at W=8 and W=16 with directed vectors.
module tb_seq_alu;

  typedef struct {
    logic [31:0] r;
    logic        f;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [2:0]  sel8 = '0;
  logic        busy8, done8, flag8, zero8;
  logic [15:0] res8;

  logic        start16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [2:0]  sel16 = '0;
  logic        busy16, done16, flag16, zero16;
  logic [31:0] res16;

  seq_alu #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .sel(sel8), .busy(busy8), .done(done8), .result(res8), .flag(flag8), .zero(zero8)
  );

  seq_alu #(.W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .sel(sel16), .busy(busy16), .done(done16), .result(res16), .flag(flag16), .zero(zero16)
  );

  exp_t q8[$];
  exp_t q16[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done8) begin
      if (q8.size() == 0) check("w8_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q8.pop_front();
        check("w8_result", 32'(res8), e.r);
        check("w8_flag", 32'(flag8), 32'(e.f));
        check("w8_zero", 32'(zero8), 32'(e.z));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done16) begin
      if (q16.size() == 0) check("w16_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q16.pop_front();
        check("w16_result", res16, e.r);
        check("w16_flag", 32'(flag16), 32'(e.f));
        check("w16_zero", 32'(zero16), 32'(e.z));
      end
    end
  end

  // Issue one op, scramble inputs after accept, and check done latency.
  task automatic op(input bit w16, input logic [2:0] s, input logic [15:0] x, input logic [15:0] y,
                    input logic ci, input logic [31:0] er, input logic ef, input logic ez,
                    input int lat);
    int n;
    logic d;
    if (w16) begin
      sel16 = s; a16 = x; b16 = y; cin16 = ci; start16 = 1'b1;
      q16.push_back('{er, ef, ez});
    end else begin
      sel8 = s; a8 = x[7:0]; b8 = y[7:0]; cin8 = ci; start8 = 1'b1;
      q8.push_back('{er, ef, ez});
    end
    @(posedge clk); #1;
    start8 = 1'b0; start16 = 1'b0;
    sel8 = ~s; a8 = ~a8; b8 = ~b8; cin8 = ~ci;
    sel16 = ~s; a16 = ~a16; b16 = ~b16; cin16 = ~ci;
    n = 0;
    d = w16 ? done16 : done8;
    while (!d && n < 40) begin
      @(posedge clk); #1;
      n++;
      d = w16 ? done16 : done8;
    end
    check(w16 ? "w16_latency" : "w8_latency", 32'(n), 32'(lat));
    @(negedge clk); #1;
  endtask

  initial begin
    logic any_done;
    #2;
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_result", 32'(res8), 32'd0);
    check("rst_flag_zero", 32'({flag8, zero8}), 32'd0);
    check("rst_result16", res16, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // W=8 single-cycle ops
    op(0, 3'b000, 16'h55, 16'hAA, 1'b0, 32'h00FF, 1'b0, 1'b0, 1);
    op(0, 3'b000, 16'hFF, 16'h01, 1'b0, 32'h0100, 1'b1, 1'b0, 1);
    op(0, 3'b000, 16'h7F, 16'h80, 1'b1, 32'h0100, 1'b1, 1'b0, 1);
    op(0, 3'b001, 16'h01, 16'h01, 1'b0, 32'h0000, 1'b0, 1'b1, 1);
    op(0, 3'b001, 16'h00, 16'h01, 1'b0, 32'h00FF, 1'b1, 1'b0, 1);
    op(0, 3'b001, 16'h05, 16'h03, 1'b1, 32'h0001, 1'b0, 1'b0, 1);
    op(0, 3'b001, 16'h03, 16'h03, 1'b1, 32'h00FF, 1'b1, 1'b0, 1);
    op(0, 3'b010, 16'hF0, 16'h0F, 1'b1, 32'h0000, 1'b0, 1'b1, 1);
    op(0, 3'b011, 16'hF0, 16'h0C, 1'b0, 32'h00FC, 1'b0, 1'b0, 1);
    op(0, 3'b100, 16'hF0, 16'hFF, 1'b0, 32'h000F, 1'b0, 1'b0, 1);
    op(0, 3'b110, 16'h81, 16'h07, 1'b0, 32'h4080, 1'b1, 1'b0, 1);
    op(0, 3'b110, 16'h81, 16'h0F, 1'b0, 32'h8000, 1'b1, 1'b0, 1);
    op(0, 3'b110, 16'h81, 16'h10, 1'b0, 32'h0081, 1'b0, 1'b0, 1);
    op(0, 3'b111, 16'h05, 16'h05, 1'b0, 32'h0000, 1'b0, 1'b1, 1);
    op(0, 3'b101, 16'h00, 16'h37, 1'b0, 32'h0000, 1'b0, 1'b1, 8);
    op(0, 3'b101, 16'h0F, 16'h0F, 1'b0, 32'h00E1, 1'b0, 1'b0, 8);

    // MUL 0xFF*0xFF with busy profile and an ignored start at N+3
    sel8 = 3'b101; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    q8.push_back('{32'hFE01, 1'b1, 1'b0});
    @(posedge clk); #1;
    start8 = 1'b0;
    check("mul_busy_n", 32'(busy8), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin sel8 = 3'b000; a8 = 8'h01; b8 = 8'h01; start8 = 1'b1; end
      if (k == 3) start8 = 1'b0;
      check("mul_busy", 32'(busy8), (k < 8) ? 32'd1 : 32'd0);
      check("mul_done", 32'(done8), (k == 8) ? 32'd1 : 32'd0);
    end
    repeat (4) @(posedge clk);
    #1;

    // Reset during a multiply: outputs clear at once, no done afterwards
    sel8 = 3'b101; a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_result", 32'(res8), 32'd0);
    check("midrst_flags", 32'({busy8, done8, flag8, zero8}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    any_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      any_done = any_done | done8 | busy8;
    end
    check("postrst_quiet", 32'(any_done), 32'd0);

    // Back-to-back ADD with start held for 3 cycles
    sel8 = 3'b000; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    for (int k = 0; k < 3; k++) q8.push_back('{32'h0002, 1'b0, 1'b0});
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) start8 = 1'b0;
      @(posedge clk); #1;
      check("b2b_done", 32'(done8), 32'd1);
    end
    @(posedge clk); #1;
    check("b2b_done_end", 32'(done8), 32'd0);
    op(0, 3'b111, 16'h03, 16'h07, 1'b0, 32'h0000, 1'b1, 1'b0, 1);

    // W=16
    op(1, 3'b101, 16'hFFFF, 16'h0002, 1'b0, 32'h0001FFFE, 1'b1, 1'b0, 16);
    op(1, 3'b110, 16'h8001, 16'h0001, 1'b0, 32'h00010002, 1'b1, 1'b0, 1);
    op(1, 3'b000, 16'hFFFF, 16'hFFFF, 1'b1, 32'h0001FFFF, 1'b1, 1'b0, 1);

    repeat (3) @(posedge clk);
    #1;
    check("w8_queue_empty", 32'(q8.size()), 32'd0);
    check("w16_queue_empty", 32'(q16.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
